// File: rtl/ir_cmd_if.sv
// Command handshake between ir_cmd_controller and its consumer.
// valid/ready: the master raises cmd_valid with cmd_code/cmd_repeat stable and
// holds all three until an edge where cmd_valid & cmd_ready are both high;
// that edge is the transfer. cmd_ready while cmd_valid is low has no effect.
interface ir_cmd_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_code;
  logic       cmd_repeat;

  modport master (
    output cmd_valid,
    output cmd_code,
    output cmd_repeat,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_code,
    input  cmd_repeat,
    output cmd_ready
  );
endinterface

// File: rtl/ir_cmd_controller.sv
// Collects a two-byte IR frame (code, ~code) from the slow reader, rearms the
// reader after each byte, validates the frame and offers the code on a
// valid/ready handshake with a repeat flag. Rejected frames are counted.
module ir_cmd_controller #(
  parameter logic [23:0] TIMEOUT       = 24'd5_000_000,
  parameter logic [15:0] REARM_CYCLES  = 16'd10_000,
  parameter logic [23:0] REPEAT_WINDOW = 24'd5_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ir_avail,
  input  logic [7:0]  ir_data,
  output logic        ir_rearm,
  ir_cmd_if.master    cmd,
  output logic [7:0]  err_count,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REARM_A = 3'd1;
  localparam logic [2:0] DRAIN_A = 3'd2;
  localparam logic [2:0] WAIT_B  = 3'd3;
  localparam logic [2:0] REARM_B = 3'd4;
  localparam logic [2:0] DRAIN_B = 3'd5;
  localparam logic [2:0] OUTPUT  = 3'd6;

  logic [2:0]  state, state_next;
  logic        avail_meta, avail_s;
  logic [7:0]  byte0, byte1;
  logic [15:0] rearm_cnt;
  logic [23:0] tmo_cnt;
  logic [23:0] rpt_timer;
  logic [7:0]  last_code;
  logic        have_last;
  logic [7:0]  code_q;
  logic        repeat_q;
  logic        rearm_last, tmo_hit, err_inc, frame_ok, xfer;

  assign ir_rearm       = (state == REARM_A) || (state == REARM_B);
  assign cmd.cmd_valid  = (state == OUTPUT);
  assign cmd.cmd_code   = code_q;
  assign cmd.cmd_repeat = repeat_q;
  assign state_dbg      = state;

  assign rearm_last = (rearm_cnt == REARM_CYCLES - 16'd1);
  assign tmo_hit    = (tmo_cnt == TIMEOUT - 24'd1);
  assign frame_ok   = (byte1 == ~byte0);
  assign xfer       = (state == OUTPUT) && cmd.cmd_ready;

  // Two-flop synchronizer for the reader's full flag (reader clock domain).
  always_ff @(posedge clk) begin
    if (!reset) begin
      avail_meta <= 1'b0;
      avail_s    <= 1'b0;
    end else begin
      avail_meta <= ir_avail;
      avail_s    <= avail_meta;
    end
  end

  // Next-state decode; a capture in WAIT_B takes priority over the timeout.
  always_comb begin
    state_next = state;
    err_inc    = 1'b0;
    case (state)
      IDLE:    if (avail_s) state_next = REARM_A;
      REARM_A: begin
        if (tmo_hit) begin
          state_next = IDLE;
          err_inc    = 1'b1;
        end else if (rearm_last) begin
          state_next = DRAIN_A;
        end
      end
      DRAIN_A: begin
        if (tmo_hit) begin
          state_next = IDLE;
          err_inc    = 1'b1;
        end else if (!avail_s) begin
          state_next = WAIT_B;
        end
      end
      WAIT_B: begin
        if (avail_s) begin
          state_next = REARM_B;
        end else if (tmo_hit) begin
          state_next = IDLE;
          err_inc    = 1'b1;
        end
      end
      REARM_B: if (rearm_last) state_next = DRAIN_B;
      DRAIN_B: begin
        if (!avail_s) begin
          if (frame_ok) begin
            state_next = OUTPUT;
          end else begin
            state_next = IDLE;
            err_inc    = 1'b1;
          end
        end
      end
      OUTPUT:  if (cmd.cmd_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, frame capture, counters and the delivered-command registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      byte0     <= 8'd0;
      byte1     <= 8'd0;
      rearm_cnt <= 16'd0;
      tmo_cnt   <= 24'd0;
      rpt_timer <= REPEAT_WINDOW;
      last_code <= 8'd0;
      have_last <= 1'b0;
      code_q    <= 8'd0;
      repeat_q  <= 1'b0;
      err_count <= 8'd0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);

      if (state == IDLE && avail_s) begin
        byte0   <= ir_data;
        tmo_cnt <= 24'd0;
      end else if (state == REARM_A || state == DRAIN_A || state == WAIT_B) begin
        tmo_cnt <= tmo_cnt + 24'd1;
      end

      if (state == WAIT_B && avail_s) byte1 <= ir_data;

      rearm_cnt <= (ir_rearm && !rearm_last) ? rearm_cnt + 16'd1 : 16'd0;

      if (state == DRAIN_B && !avail_s && frame_ok) begin
        code_q   <= byte0;
        repeat_q <= have_last && (byte0 == last_code) && (rpt_timer < REPEAT_WINDOW);
      end

      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;

      if (xfer) begin
        last_code <= code_q;
        have_last <= 1'b1;
        rpt_timer <= 24'd0;
      end else if (rpt_timer < REPEAT_WINDOW) begin
        rpt_timer <= rpt_timer + 24'd1;
      end
    end
  end

endmodule

// File: doc/ir_cmd_controller.md
# ir_cmd_controller

Sequencer that sits between the IR reader datapath (8-bit shift register with `avail` flag, clocked at 10 kHz) and the system-clock command consumer in the main top module. It collects two consecutive bytes from the reader into a frame: command code, then its bitwise complement. After each byte it rearms the reader, checks the frame, and presents valid commands on a valid/ready handshake with a repeat flag. Bad frames and timeouts are counted.

## Interface
- `TIMEOUT`, 24'd5_000_000: max system-clock cycles from byte-0 capture to byte-1 capture.
- `REARM_CYCLES`, 16'd10_000: length of the `ir_rearm` pulse. Must exceed two reader-clock periods.
- `REPEAT_WINDOW`, 24'd5_000_000: cycles after a delivery during which the same code is flagged as a repeat.
- `clk`  in  1  system clock; the only clock in the block.
- `reset`  in  1  synchronous, active-low reset.
- `ir_avail`  in  1  reader full flag, asynchronous to `clk`; level, held until the reader is reset.
- `ir_data`  in  8  reader byte; stable while `ir_avail` is high.
- `ir_rearm`  out  1  reset request to the reader; active high.
- `cmd_valid`  out  1  command available.
- `cmd_ready`  in  1  consumer accepts the command.
- `cmd_code`  out  8  validated command code.
- `cmd_repeat`  out  1  `cmd_code` equals the previous delivered code and arrived within `REPEAT_WINDOW`.
- `err_count`  out  8  saturating count of rejected frames (complement mismatch or timeout).
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- `ir_avail` passes through a 2-flop synchronizer to give `avail_s`. `ir_data` is sampled directly; it is safe because it is stable while `avail_s` is high.
- FSM states and transitions:
  - IDLE: if `avail_s`, capture `byte0 <= ir_data`, clear the timeout counter, go to REARM_A.
  - REARM_A: `ir_rearm=1` for exactly `REARM_CYCLES` cycles, then go to DRAIN_A.
  - DRAIN_A: wait for `avail_s==0`, then go to WAIT_B.
  - WAIT_B: if `avail_s`, capture `byte1 <= ir_data` and go to REARM_B.
  - REARM_B: same as REARM_A, then go to DRAIN_B.
  - DRAIN_B: when `avail_s==0`:
    - if `byte1 == ~byte0`, load `cmd_code <= byte0`, compute `cmd_repeat`, go to OUTPUT;
    - otherwise increment `err_count` and go to IDLE.
  - OUTPUT: hold `cmd_valid=1`. On `cmd_valid & cmd_ready`:
    - record `last_code <= cmd_code` and set `have_last`;
    - clear the repeat timer;
    - go to IDLE.
- Timeout counter:
  - Increments every cycle in REARM_A, DRAIN_A and WAIT_B.
  - When it reaches `TIMEOUT`, increment `err_count` and go to IDLE, discarding `byte0`. This also covers `avail` stuck high in DRAIN_A.
  - It does not run in REARM_B, DRAIN_B or OUTPUT.
- Repeat timer:
  - Saturates at `REPEAT_WINDOW`; it is counting whenever it is below that value.
  - `cmd_repeat = have_last & (byte0==last_code) & (timer < REPEAT_WINDOW)`, evaluated when loading OUTPUT.
- `err_count` saturates at 255; it never wraps.
- Bytes that arrive while the FSM is in OUTPUT are not lost. The reader holds `avail` high, and IDLE captures the byte after the handshake completes.
- `ir_rearm` is deasserted in every state except REARM_A and REARM_B.

## Timing
- Reset (`reset==0` at a `clk` edge):
  - state becomes IDLE;
  - `ir_rearm`, `cmd_valid`, `cmd_code`, `cmd_repeat`, `err_count` and `busy` become 0;
  - `have_last` becomes 0, the repeat timer is set to `REPEAT_WINDOW`, and the synchronizer flops are cleared.
- Reset in any state aborts the frame without incrementing `err_count`. The reader is reset by the system reset separately.
- `ir_avail` rising to byte capture: 3 `clk` edges (2 synchronizer edges plus 1 capture edge). `ir_rearm` is high from the cycle after the capture.
- `cmd_valid` rises on the edge on which DRAIN_B sees `avail_s==0` with a matching complement.
- `cmd_code` and `cmd_repeat` are stable for as long as `cmd_valid` is high.
- Transfer happens on an edge with `cmd_valid & cmd_ready` both high; `cmd_valid` is low the next cycle.
- `cmd_ready` asserted while `cmd_valid` is low has no effect.
- `busy` is registered; it equals `(state != IDLE)`.
- Simultaneous events:
  - timeout edge and `avail_s` rising in WAIT_B: the capture wins;
  - `err_count` at 255: the increment is suppressed.

## Test plan
All scenarios use `TIMEOUT=100`, `REARM_CYCLES=4` and `REPEAT_WINDOW=200`.
- Reset, then idle: all outputs are 0 and `busy=0`.
- Frame 0x3C then 0xC3, with `cmd_ready=1`:
  - two `ir_rearm` pulses, each exactly 4 cycles;
  - `cmd_valid` high for 1 cycle with `cmd_code=0x3C`, `cmd_repeat=0`.
- Same frame again 50 cycles after the handshake: `cmd_repeat=1`. Same frame 300 cycles after: `cmd_repeat=0`.
- Frame 0x3C then 0x3C: no `cmd_valid`, `err_count=1`, FSM returns to IDLE.
- Byte 0x12 with no second byte: after 100 cycles `err_count` increments and `busy` falls. A later good frame is then delivered.
- Hold `cmd_ready=0` for 500 cycles while a third byte arrives: `cmd_code` stays stable. After `cmd_ready`, the pending byte is captured as `byte0` within 3 cycles.
